// File: rtl/cnn_frame_loader.sv
// Front-end for the CNN classifier: loads one 28x28 pixel frame into image memory, starts inference, returns the digit.
// Defining LOADER_CHECKSUM_EN adds an 18-bit pixel-sum checksum of the last accepted frame.
module cnn_frame_loader #(
   parameter int NUM_PIXELS     = 784,
   parameter int ADDR_W         = 10,
   parameter int TIMEOUT_CYCLES = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              s_valid,
   input  logic [7:0]        s_data,
   input  logic              s_last,
   output logic              s_ready,
   output logic              img_we,
   output logic [ADDR_W-1:0] img_addr,
   output logic [7:0]        img_data,
   output logic              cnn_start,
   input  logic              cnn_done,
   input  logic [3:0]        cnn_result,
   output logic [3:0]        result,
   output logic              result_valid,
   input  logic              result_ready,
   output logic              frame_err,
   output logic              busy,
   output logic [17:0]       checksum
);

   localparam int                TW       = $clog2(TIMEOUT_CYCLES + 2);
   localparam bit                TO_EN    = (TIMEOUT_CYCLES > 0);
   localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NUM_PIXELS - 1);
   localparam logic [TW-1:0]     TO_LAST  = TO_EN ? TW'(TIMEOUT_CYCLES - 1) : '0;

   typedef enum logic [2:0] {LOAD, DRAIN, START, WAIT, HOLD} state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] pix_cnt, pix_cnt_nxt;
   logic [TW-1:0]     tcnt;
   logic              accept, load_beat, is_last_pix, timeout_hit;
   logic              err_nxt, start_nxt;

   assign s_ready     = !rst && (state == LOAD || state == DRAIN);
   assign busy        = !rst && (state != LOAD || pix_cnt != '0);
   assign accept      = s_valid && s_ready;
   assign load_beat   = accept && (state == LOAD);
   assign is_last_pix = (pix_cnt == LAST_PIX);
   assign timeout_hit = TO_EN && (tcnt == TO_LAST);

   always_comb begin
      state_nxt   = state;
      pix_cnt_nxt = pix_cnt;
      err_nxt     = 1'b0;
      start_nxt   = 1'b0;
      case (state)
         LOAD: begin
            if (accept) begin
               if (is_last_pix) begin
                  pix_cnt_nxt = '0;
                  state_nxt   = s_last ? START : DRAIN;
               end else if (s_last) begin
                  pix_cnt_nxt = '0;
                  err_nxt     = 1'b1;
               end else begin
                  pix_cnt_nxt = pix_cnt + 1'b1;
               end
            end
         end
         DRAIN: begin
            if (accept && s_last) begin
               err_nxt   = 1'b1;
               state_nxt = LOAD;
            end
         end
         START: begin
            // Registered start lands one cycle after the final write; hold off while done is still up.
            if (!cnn_done) begin
               start_nxt = 1'b1;
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            if (cnn_done) begin
               state_nxt = HOLD;
            end else if (timeout_hit) begin
               err_nxt   = 1'b1;
               state_nxt = LOAD;
            end
         end
         HOLD: begin
            if (result_ready) state_nxt = LOAD;
         end
         default: state_nxt = LOAD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= LOAD;
         pix_cnt      <= '0;
         tcnt         <= '0;
         img_we       <= 1'b0;
         img_addr     <= '0;
         img_data     <= '0;
         cnn_start    <= 1'b0;
         frame_err    <= 1'b0;
         result       <= '0;
         result_valid <= 1'b0;
      end else begin
         state     <= state_nxt;
         pix_cnt   <= pix_cnt_nxt;
         img_we    <= load_beat;
         cnn_start <= start_nxt;
         frame_err <= err_nxt;
         tcnt      <= (state == WAIT) ? tcnt + 1'b1 : '0;
         if (load_beat) begin
            img_addr <= pix_cnt;
            img_data <= s_data;
         end
         if (state == WAIT && cnn_done) begin
            result       <= cnn_result;
            result_valid <= 1'b1;
         end else if (state == HOLD && result_ready) begin
            result_valid <= 1'b0;
         end
      end
   end

`ifdef LOADER_CHECKSUM_EN
   logic [17:0] acc, acc_sum, checksum_q;

   // The first pixel of a frame restarts the sum, so no separate clear on frame start is needed.
   assign acc_sum  = ((pix_cnt == '0) ? 18'd0 : acc) + 18'(s_data);
   assign checksum = checksum_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         acc        <= '0;
         checksum_q <= '0;
      end else if (load_beat) begin
         if (is_last_pix) begin
            acc <= '0;
            if (s_last) checksum_q <= acc_sum;
         end else if (s_last) begin
            acc <= '0;
         end else begin
            acc <= acc_sum;
         end
      end
   end
`else
   assign checksum = '0;
`endif

endmodule

// File: tb/tb_cnn_frame_loader.sv
// Bench for cnn_frame_loader: random pixel frames against a frame-level memory/checksum model and a classifier responder.
module tb_cnn_frame_loader;
   localparam int NP = 784;
   localparam int AW = 10;
   localparam int TO = 100;
`ifdef LOADER_CHECKSUM_EN
   localparam bit CK_EN = 1'b1;
`else
   localparam bit CK_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          s_valid = 1'b0;
   logic [7:0]    s_data = '0;
   logic          s_last = 1'b0;
   logic          s_ready;
   logic          img_we;
   logic [AW-1:0] img_addr;
   logic [7:0]    img_data;
   logic          cnn_start;
   logic          cnn_done = 1'b0;
   logic [3:0]    cnn_result = '0;
   logic [3:0]    result;
   logic          result_valid;
   logic          result_ready = 1'b0;
   logic          frame_err;
   logic          busy;
   logic [17:0]   checksum;

   always #5 clk = ~clk;

   cnn_frame_loader #(.NUM_PIXELS(NP), .ADDR_W(AW), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
      .img_we(img_we), .img_addr(img_addr), .img_data(img_data), .cnn_start(cnn_start),
      .cnn_done(cnn_done), .cnn_result(cnn_result), .result(result), .result_valid(result_valid),
      .result_ready(result_ready), .frame_err(frame_err), .busy(busy), .checksum(checksum)
   );

   int vectors = 0;
   int miscompares = 0;
   bit stuck = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Observed side: what reached image memory and how often start/err fired.
   int wr_cnt, dup_cnt, start_cnt, err_cnt, last_wr_cyc, start_cyc, err_cyc, max_addr, first_addr;
   logic [7:0] got_mem [0:1023];
   bit seen [0:1023];

   always @(negedge clk) begin
      if (!rst) begin
         if (img_we) begin
            if (seen[img_addr]) dup_cnt++;
            seen[img_addr] = 1'b1;
            got_mem[img_addr] = img_data;
            if (wr_cnt == 0) first_addr = int'(img_addr);
            if (int'(img_addr) > max_addr) max_addr = int'(img_addr);
            wr_cnt++;
            last_wr_cyc = cyc;
         end
         if (cnn_start) begin start_cnt++; start_cyc = cyc; end
         if (frame_err) begin err_cnt++; err_cyc = cyc; end
      end
   end

   // Classifier responder: done rises done_delay cycles after start and stays up for 4 cycles.
   bit cls_en = 1'b1;
   int done_delay = 50;
   logic [3:0] next_digit = 4'd7;
   int cd = 0, dh = 0;
   always @(negedge clk) begin
      if (rst) begin
         cd = 0; dh = 0; cnn_done = 1'b0;
      end else begin
         if (dh > 0) begin dh--; if (dh == 0) cnn_done = 1'b0; end
         if (cnn_start && cls_en) cd = done_delay;
         else if (cd > 0) begin
            cd--;
            if (cd == 0) begin cnn_done = 1'b1; cnn_result = next_digit; dh = 4; end
         end
      end
   end

   // Reference model: expected memory image and pixel sum of the frame just sent.
   logic [7:0]  exp_mem [0:NP-1];
   int          frame_sum;
   logic [17:0] ck_model = '0;

   task automatic clear_mon();
      @(posedge clk); #1;
      wr_cnt = 0; dup_cnt = 0; start_cnt = 0; err_cnt = 0; last_wr_cyc = -1;
      start_cyc = -1; err_cyc = -1; max_addr = -1; first_addr = -1;
      for (int i = 0; i < 1024; i++) begin seen[i] = 1'b0; got_mem[i] = '0; end
   endtask

   task automatic drive_beat(input logic [7:0] d, input logic l, input bit gaps);
      int guard = 0;
      bit taken = 0;
      while (!taken && !stuck) begin
         @(negedge clk);
         guard++;
         if (guard > 2000) begin
            vectors++; miscompares++; stuck = 1;
            $display("FAIL beat_accept s_ready got %b want 1", s_ready);
            s_valid = 1'b0;
         end else if (gaps && $urandom_range(0, 1) == 0) begin
            s_valid = 1'b0;
         end else begin
            s_valid = 1'b1; s_data = d; s_last = l;
            taken = (s_ready === 1'b1);
         end
      end
   endtask

   task automatic send_frame(input int nbeats, input int last_at, input bit gaps, input bit rnd);
      logic [7:0] d;
      frame_sum = 0;
      for (int i = 0; i < nbeats; i++) begin
         d = rnd ? 8'($urandom_range(0, 255)) : 8'(i % 256);
         if (i < NP) begin exp_mem[i] = d; frame_sum += int'(d); end
         drive_beat(d, i == last_at, gaps);
      end
      @(negedge clk);
      s_valid = 1'b0; s_last = 1'b0;
   endtask

   task automatic wait_result(input string name);
      int g = 0;
      while (result_valid !== 1'b1 && g < 3000) begin @(negedge clk); g++; end
      vectors++;
      if (result_valid !== 1'b1) begin
         miscompares++;
         $display("FAIL %s_result_valid got %b want 1", name, result_valid);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      vectors++; if (s_ready !== 1'b0) begin miscompares++; $display("FAIL rst_s_ready got %b want 0", s_ready); end
      vectors++; if (img_we !== 1'b0) begin miscompares++; $display("FAIL rst_img_we got %b want 0", img_we); end
      vectors++; if (img_addr !== '0) begin miscompares++; $display("FAIL rst_img_addr got %0d want 0", img_addr); end
      vectors++; if (cnn_start !== 1'b0) begin miscompares++; $display("FAIL rst_cnn_start got %b want 0", cnn_start); end
      vectors++; if (result_valid !== 1'b0) begin miscompares++; $display("FAIL rst_result_valid got %b want 0", result_valid); end
      vectors++; if (result !== 4'd0) begin miscompares++; $display("FAIL rst_result got %0d want 0", result); end
      vectors++; if (frame_err !== 1'b0) begin miscompares++; $display("FAIL rst_frame_err got %b want 0", frame_err); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got %b want 0", busy); end
      vectors++; if (checksum !== 18'd0) begin miscompares++; $display("FAIL rst_checksum got %0d want 0", checksum); end
      rst = 1'b0;
      @(negedge clk);
      vectors++; if (s_ready !== 1'b1) begin miscompares++; $display("FAIL post_rst_s_ready got %b want 1", s_ready); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL post_rst_busy got %b want 0", busy); end
   endtask

   task automatic test_nominal();
      int bad = 0;
      clear_mon();
      next_digit = 4'd7;
      send_frame(NP, NP - 1, 1'b0, 1'b0);
      ck_model = CK_EN ? 18'(frame_sum) : 18'd0;
      wait_result("nominal");
      for (int i = 0; i < NP; i++) if (!seen[i] || got_mem[i] !== exp_mem[i]) bad++;
      vectors++; if (bad != 0) begin miscompares++; $display("FAIL nominal_mem bad_addrs got %0d want 0", bad); end
      vectors++; if (wr_cnt != NP) begin miscompares++; $display("FAIL nominal_writes got %0d want %0d", wr_cnt, NP); end
      vectors++; if (dup_cnt != 0) begin miscompares++; $display("FAIL nominal_dups got %0d want 0", dup_cnt); end
      vectors++; if (start_cnt != 1) begin miscompares++; $display("FAIL nominal_starts got %0d want 1", start_cnt); end
      vectors++; if (start_cyc <= last_wr_cyc) begin miscompares++; $display("FAIL nominal_start_order start_cyc %0d want > last_wr %0d", start_cyc, last_wr_cyc); end
      vectors++; if (result !== 4'd7) begin miscompares++; $display("FAIL nominal_result got %0d want 7", result); end
      vectors++; if (checksum !== ck_model) begin miscompares++; $display("FAIL nominal_checksum got %0d want %0d", checksum, ck_model); end
      vectors++; if (err_cnt != 0) begin miscompares++; $display("FAIL nominal_err got %0d want 0", err_cnt); end
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL nominal_busy got %b want 1", busy); end
      result_ready = 1'b1;
      @(negedge clk);
      result_ready = 1'b0;
      vectors++; if (result_valid !== 1'b0) begin miscompares++; $display("FAIL nominal_rv_clear got %b want 0", result_valid); end
      vectors++; if (s_ready !== 1'b1) begin miscompares++; $display("FAIL nominal_s_ready_after got %b want 1", s_ready); end
   endtask

   task automatic test_gaps();
      int bad = 0;
      logic [3:0] dig;
      dig = 4'($urandom_range(0, 9));
      next_digit = dig;
      done_delay = int'($urandom_range(5, 60));
      clear_mon();
      send_frame(NP, NP - 1, 1'b1, 1'b1);
      ck_model = CK_EN ? 18'(frame_sum) : 18'd0;
      wait_result("gaps");
      for (int i = 0; i < NP; i++) if (!seen[i] || got_mem[i] !== exp_mem[i]) bad++;
      vectors++; if (bad != 0) begin miscompares++; $display("FAIL gaps_mem bad_addrs got %0d want 0", bad); end
      vectors++; if (wr_cnt != NP || dup_cnt != 0) begin miscompares++; $display("FAIL gaps_writes got %0d dups %0d want %0d dups 0", wr_cnt, dup_cnt, NP); end
      vectors++; if (start_cnt != 1) begin miscompares++; $display("FAIL gaps_starts got %0d want 1", start_cnt); end
      vectors++; if (result !== dig) begin miscompares++; $display("FAIL gaps_result got %0d want %0d", result, dig); end
      vectors++; if (checksum !== ck_model) begin miscompares++; $display("FAIL gaps_checksum got %0d want %0d", checksum, ck_model); end
      result_ready = 1'b1;
      @(negedge clk);
      result_ready = 1'b0;
      done_delay = 50;
   endtask

   task automatic test_early_last();
      logic [3:0] dig;
      clear_mon();
      send_frame(100, 99, 1'b0, 1'b1);
      repeat (10) @(negedge clk);
      vectors++; if (err_cnt != 1) begin miscompares++; $display("FAIL early_err_pulses got %0d want 1", err_cnt); end
      vectors++; if (start_cnt != 0) begin miscompares++; $display("FAIL early_starts got %0d want 0", start_cnt); end
      vectors++; if (wr_cnt != 100) begin miscompares++; $display("FAIL early_writes got %0d want 100", wr_cnt); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL early_busy got %b want 0", busy); end
      vectors++; if (checksum !== ck_model) begin miscompares++; $display("FAIL early_checksum_held got %0d want %0d", checksum, ck_model); end
      dig = 4'($urandom_range(0, 9));
      next_digit = dig;
      clear_mon();
      send_frame(NP, NP - 1, 1'b0, 1'b1);
      ck_model = CK_EN ? 18'(frame_sum) : 18'd0;
      wait_result("early_next");
      vectors++; if (first_addr != 0) begin miscompares++; $display("FAIL early_next_first_addr got %0d want 0", first_addr); end
      vectors++; if (wr_cnt != NP || start_cnt != 1) begin miscompares++; $display("FAIL early_next_counts got wr %0d st %0d want %0d 1", wr_cnt, start_cnt, NP); end
      vectors++; if (result !== dig) begin miscompares++; $display("FAIL early_next_result got %0d want %0d", result, dig); end
      vectors++; if (checksum !== ck_model) begin miscompares++; $display("FAIL early_next_checksum got %0d want %0d", checksum, ck_model); end
      result_ready = 1'b1;
      @(negedge clk);
      result_ready = 1'b0;
   endtask

   task automatic test_long_frame();
      clear_mon();
      send_frame(800, 799, 1'b0, 1'b1);
      repeat (10) @(negedge clk);
      vectors++; if (wr_cnt != NP || dup_cnt != 0) begin miscompares++; $display("FAIL long_writes got %0d dups %0d want %0d dups 0", wr_cnt, dup_cnt, NP); end
      vectors++; if (max_addr != NP - 1) begin miscompares++; $display("FAIL long_max_addr got %0d want %0d", max_addr, NP - 1); end
      vectors++; if (err_cnt != 1) begin miscompares++; $display("FAIL long_err_pulses got %0d want 1", err_cnt); end
      vectors++; if (start_cnt != 0) begin miscompares++; $display("FAIL long_starts got %0d want 0", start_cnt); end
      vectors++; if (busy !== 1'b0 || s_ready !== 1'b1) begin miscompares++; $display("FAIL long_idle got busy %b rdy %b want 0 1", busy, s_ready); end
      vectors++; if (checksum !== ck_model) begin miscompares++; $display("FAIL long_checksum_held got %0d want %0d", checksum, ck_model); end
   endtask

   task automatic test_hold();
      logic [3:0] dig;
      dig = 4'($urandom_range(0, 9));
      next_digit = dig;
      clear_mon();
      send_frame(NP, NP - 1, 1'b1, 1'b1);
      ck_model = CK_EN ? 18'(frame_sum) : 18'd0;
      wait_result("hold");
      for (int k = 0; k < 20; k++) begin
         vectors++;
         if (result !== dig || result_valid !== 1'b1 || s_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL hold_stable cycle %0d got res %0d rv %b rdy %b want %0d 1 0", k, result, result_valid, s_ready, dig);
         end
         @(negedge clk);
      end
      result_ready = 1'b1;
      @(negedge clk);
      result_ready = 1'b0;
      vectors++; if (result_valid !== 1'b0) begin miscompares++; $display("FAIL hold_rv_clear got %b want 0", result_valid); end
      vectors++; if (s_ready !== 1'b1) begin miscompares++; $display("FAIL hold_s_ready_after got %b want 1", s_ready); end
   endtask

   task automatic test_reset_mid();
      int g = 0;
      clear_mon();
      send_frame(400, -1, 1'b0, 1'b1);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      vectors++; if (img_we !== 1'b0 || cnn_start !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b0) begin
         miscompares++; $display("FAIL rstload_outputs got we %b st %b busy %b rdy %b want 0", img_we, cnn_start, busy, s_ready); end
      vectors++; if (checksum !== 18'd0 || img_addr !== '0 || img_data !== 8'd0) begin
         miscompares++; $display("FAIL rstload_regs got ck %0d addr %0d data %0d want 0", checksum, img_addr, img_data); end
      rst = 1'b0;
      ck_model = '0;
      clear_mon();
      repeat (100) @(negedge clk);
      vectors++; if (start_cnt != 0 || wr_cnt != 0 || busy !== 1'b0) begin
         miscompares++; $display("FAIL rstload_after got st %0d wr %0d busy %b want 0", start_cnt, wr_cnt, busy); end
      cls_en = 1'b0;
      clear_mon();
      send_frame(NP, NP - 1, 1'b0, 1'b1);
      while (start_cnt == 0 && g < 200) begin @(negedge clk); g++; end
      repeat (10) @(negedge clk);
      vectors++; if (start_cnt != 1 || busy !== 1'b1) begin
         miscompares++; $display("FAIL rstwait_entry got st %0d busy %b want 1 1", start_cnt, busy); end
      rst = 1'b1;
      repeat (2) @(negedge clk);
      vectors++; if (result_valid !== 1'b0 || cnn_start !== 1'b0 || busy !== 1'b0 || frame_err !== 1'b0 || checksum !== 18'd0) begin
         miscompares++; $display("FAIL rstwait_outputs got rv %b st %b busy %b err %b ck %0d want 0", result_valid, cnn_start, busy, frame_err, checksum); end
      rst = 1'b0;
      ck_model = '0;
      cls_en = 1'b1;
      repeat (150) @(negedge clk);
      vectors++; if (start_cnt != 1 || err_cnt != 0 || result_valid !== 1'b0) begin
         miscompares++; $display("FAIL rstwait_after got st %0d err %0d rv %b want 1 0 0", start_cnt, err_cnt, result_valid); end
   endtask

   task automatic test_timeout();
      int g = 0;
      cls_en = 1'b0;
      clear_mon();
      send_frame(NP, NP - 1, 1'b1, 1'b1);
      ck_model = CK_EN ? 18'(frame_sum) : 18'd0;
      while (err_cnt == 0 && g < 1000) begin @(negedge clk); g++; end
      vectors++; if (err_cnt != 1) begin miscompares++; $display("FAIL timeout_err got %0d want 1", err_cnt); end
      vectors++; if (err_cyc - start_cyc != TO) begin miscompares++; $display("FAIL timeout_delay got %0d want %0d", err_cyc - start_cyc, TO); end
      vectors++; if (start_cnt != 1 || result_valid !== 1'b0) begin
         miscompares++; $display("FAIL timeout_no_result got st %0d rv %b want 1 0", start_cnt, result_valid); end
      @(negedge clk);
      vectors++; if (busy !== 1'b0 || s_ready !== 1'b1) begin
         miscompares++; $display("FAIL timeout_load got busy %b rdy %b want 0 1", busy, s_ready); end
      vectors++; if (checksum !== ck_model) begin miscompares++; $display("FAIL timeout_checksum got %0d want %0d", checksum, ck_model); end
      cls_en = 1'b1;
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_gaps();
      test_early_last();
      test_long_frame();
      test_hold();
      test_reset_mid();
      test_timeout();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
